// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the dual-clock FIFO: pops into a small prefetch
// ring and re-presents words as a registered valid/ready stream.
module fifo_rd_stream #(
    parameter  int DATASIZE = 8,
    parameter  int PDEPTH   = 2,
    parameter  int CNTW     = 16,
    localparam int OW       = $clog2(PDEPTH + 1),
    localparam int IW       = $clog2(PDEPTH)
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [DATASIZE-1:0] rdata,
    input  logic                rempty,
    output logic                rinc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATASIZE-1:0] out_data,
    input  logic                flush,
    output logic [OW-1:0]       occupancy,
    output logic [CNTW-1:0]     rd_count
);

    logic [DATASIZE-1:0] r_mem [PDEPTH];
    logic [IW-1:0]       r_head;
    logic [IW-1:0]       r_tail;
    logic [OW-1:0]       r_occ;
    logic                r_valid;
    logic [CNTW-1:0]     r_cnt;

    logic                w_push;
    logic                w_pop;
    logic [OW-1:0]       w_occ_nxt;

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
        return (idx == IW'(PDEPTH - 1)) ? '0 : idx + IW'(1);
    endfunction

    // Refill decision looks only at local occupancy, never at out_ready.
    always_comb begin
        rinc = ~rrst & ~flush & ~rempty & (r_occ < OW'(PDEPTH));
    end

    assign w_push = rinc;
    assign w_pop  = r_valid & out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_push && !w_pop) begin
            w_occ_nxt = r_occ + OW'(1);
        end else if (w_pop && !w_push) begin
            w_occ_nxt = r_occ - OW'(1);
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            for (int i = 0; i < PDEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_pop) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
            if (w_push) begin
                r_mem[r_tail] <= rdata;
            end
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_occ   <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_tail <= f_next(r_tail);
                end
                if (w_pop) begin
                    r_head <= f_next(r_head);
                end
                r_occ   <= w_occ_nxt;
                r_valid <= (w_occ_nxt != '0);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_mem[r_head];
    assign occupancy = r_occ;
    assign rd_count  = r_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream against a queue-based model
// of the FIFO, the prefetch buffer and the delivered-word count.
module tb_fifo_rd_stream;

    localparam int PD = 2;
    localparam int CW = 4;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [7:0] rdata;
    logic       rempty;
    logic       rinc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic [1:0] occupancy;
    logic [3:0] rd_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_fifo [$];
    logic [7:0] q_buf  [$];
    logic [7:0] q_out  [$];
    int         exp_cnt;
    bit         m_rinc;
    bit         s_rinc;
    int         viol;

    fifo_rd_stream #(.DATASIZE(8), .PDEPTH(PD), .CNTW(CW)) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rdata     (rdata),
        .rempty    (rempty),
        .rinc      (rinc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .rd_count  (rd_count)
    );

    always #5 rclk = ~rclk;

    task automatic drive_fifo();
        rempty = (q_fifo.size() == 0);
        rdata  = rempty ? 8'($urandom) : q_fifo[0];
    endtask

    // One clock: model decides push/pop from its own queues, DUT runs the edge.
    task automatic cycle(input bit rdy, input bit fl);
        bit m_pop;
        out_ready = rdy;
        flush     = fl;
        #1;
        m_rinc = !fl && q_fifo.size() != 0 && q_buf.size() < PD;
        s_rinc = rinc;
        if (rinc && rempty) viol++;
        m_pop  = q_buf.size() != 0 && rdy;
        @(posedge rclk);
        if (m_pop) begin
            q_out.push_back(q_buf.pop_front());
            exp_cnt = (exp_cnt + 1) % 16;
        end
        if (fl) q_buf.delete();
        else if (m_rinc) q_buf.push_back(q_fifo.pop_front());
        #1;
        drive_fifo();
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q_buf.size() == 0 && q_fifo.size() == 0) break;
            cycle(1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        rrst = 1'b1;
        q_fifo.push_back(8'hAA);
        drive_fifo();
        #3;
        checks++;
        if (rinc !== 1'b0) begin
            failures++; $display("FAIL reset_rinc got=%b exp=0", rinc);
        end
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            failures++;
            $display("FAIL reset_state valid=%b occ=%0d exp 0/0", out_valid, occupancy);
        end
        checks++;
        if (rd_count !== 4'd0 || out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_regs cnt=%0d data=%h exp 0/00", rd_count, out_data);
        end
        q_fifo.delete();
        drive_fifo();
        q_buf.delete();
        exp_cnt = 0;
        @(negedge rclk);
        rrst = 1'b0;
    endtask

    task automatic test_stream();
        q_out.delete();
        for (int i = 0; i < 8; i++) q_fifo.push_back(8'h11 + 8'(i));
        drive_fifo();
        for (int c = 0; c < 11; c++) begin
            cycle(1'b1, 1'b0);
            checks++;
            if (s_rinc !== m_rinc) begin
                failures++; $display("FAIL stream_rinc c=%0d got=%b exp=%b", c, s_rinc, m_rinc);
            end
            checks++;
            if (occupancy !== 2'(q_buf.size()) || out_valid !== (q_buf.size() != 0)) begin
                failures++;
                $display("FAIL stream_occ c=%0d got=%0d/%b exp=%0d", c, occupancy, out_valid, q_buf.size());
            end
            if (q_buf.size() != 0) begin
                checks++;
                if (out_data !== q_buf[0]) begin
                    failures++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, out_data, q_buf[0]);
                end
            end
        end
        checks++;
        if (rd_count !== 4'd8) begin
            failures++; $display("FAIL stream_count got=%0d exp=8", rd_count);
        end
        checks++;
        if (q_out.size() != 8 || q_out[0] != 8'h11 || q_out[7] != 8'h18) begin
            failures++; $display("FAIL stream_order n=%0d exp=8", q_out.size());
        end
        checks++;
        if (viol != 0) begin
            failures++; $display("FAIL stream_underflow got=%0d exp=0", viol);
        end
    endtask

    task automatic test_backpressure();
        q_out.delete();
        for (int i = 0; i < 4; i++) q_fifo.push_back(8'h11 + 8'(i));
        drive_fifo();
        for (int c = 0; c < 4; c++) cycle(1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd2 || out_data !== 8'h11 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold occ=%0d data=%h v=%b exp 2/11/1", occupancy, out_data, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (rinc !== 1'b0) begin
            failures++; $display("FAIL bp_full_rinc got=%b exp=0", rinc);
        end
        for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0);
        checks++;
        if (q_out.size() != 4 || q_out[0] != 8'h11 || q_out[1] != 8'h12 ||
            q_out[2] != 8'h13 || q_out[3] != 8'h14) begin
            failures++; $display("FAIL bp_order n=%0d exp=4", q_out.size());
        end
        checks++;
        if (rd_count !== 4'(exp_cnt) || out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_count got=%0d exp=%0d", rd_count, exp_cnt);
        end
    endtask

    task automatic test_simultaneous();
        drain();
        q_fifo.push_back(8'h5A);
        drive_fifo();
        cycle(1'b0, 1'b0);
        q_fifo.push_back(8'hC3);
        drive_fifo();
        cycle(1'b1, 1'b0);
        checks++;
        if (occupancy !== 2'd1 || out_data !== 8'hC3) begin
            failures++; $display("FAIL simul occ=%0d data=%h exp 1/c3", occupancy, out_data);
        end
    endtask

    task automatic test_flush();
        drain();
        q_fifo.push_back(8'h31);
        q_fifo.push_back(8'h32);
        drive_fifo();
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        q_fifo.push_back(8'h21);
        drive_fifo();
        cycle(1'b0, 1'b1);
        checks++;
        if (s_rinc !== 1'b0) begin
            failures++; $display("FAIL flush_rinc got=%b exp=0", s_rinc);
        end
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_state occ=%0d v=%b exp 0/0", occupancy, out_valid);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (occupancy !== 2'd1 || out_data !== 8'h21) begin
            failures++; $display("FAIL flush_next occ=%0d data=%h exp 1/21", occupancy, out_data);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(2) == 0 && q_fifo.size() < 6) q_fifo.push_back(8'($urandom));
            drive_fifo();
            cycle($urandom_range(3) != 0, $urandom_range(15) == 0);
            checks++;
            if (s_rinc !== m_rinc) begin
                failures++; $display("FAIL rand_rinc c=%0d got=%b exp=%b", c, s_rinc, m_rinc);
            end
            checks++;
            if (occupancy !== 2'(q_buf.size()) || out_valid !== (q_buf.size() != 0)) begin
                failures++; $display("FAIL rand_occ c=%0d got=%0d exp=%0d", c, occupancy, q_buf.size());
            end
            checks++;
            if (rd_count !== 4'(exp_cnt)) begin
                failures++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, rd_count, exp_cnt);
            end
            if (q_buf.size() != 0) begin
                checks++;
                if (out_data !== q_buf[0]) begin
                    failures++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_data, q_buf[0]);
                end
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        int n;
        for (int i = 0; i < 4; i++) q_fifo.push_back(8'h40 + 8'(i));
        drive_fifo();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        #2;
        rrst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || rinc !== 1'b0) begin
            failures++;
            $display("FAIL arst_state v=%b occ=%0d rinc=%b exp 0/0/0", out_valid, occupancy, rinc);
        end
        checks++;
        if (rd_count !== 4'd0 || out_data !== 8'h00) begin
            failures++; $display("FAIL arst_regs cnt=%0d data=%h exp 0/00", rd_count, out_data);
        end
        q_fifo.delete();
        q_buf.delete();
        q_out.delete();
        exp_cnt = 0;
        drive_fifo();
        @(negedge rclk);
        rrst = 1'b0;
        for (int i = 0; i < 16; i++) q_fifo.push_back(8'h60 + 8'(i));
        drive_fifo();
        n = 0;
        while (q_out.size() < 16 && n < 40) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        checks++;
        if (q_out.size() != 16) begin
            failures++; $display("FAIL wrap_timeout got=%0d exp=16", q_out.size());
        end
        checks++;
        if (rd_count !== 4'd0) begin
            failures++; $display("FAIL wrap_count got=%0d exp=0", rd_count);
        end
        checks++;
        if (q_out.size() == 16 && (q_out[0] != 8'h60 || q_out[15] != 8'h6F)) begin
            failures++; $display("FAIL wrap_order first=%h last=%h exp 60/6f", q_out[0], q_out[15]);
        end
    endtask

    initial begin
        rrst      = 1'b1;
        out_ready = 1'b0;
        flush     = 1'b0;
        viol      = 0;
        exp_cnt   = 0;
        drive_fifo();
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
